// File: rtl/kmeans_pkg.sv
// Shared constants and state encodings for the K-means accelerator datapath blocks.
package kmeans_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int CNT_W      = 32;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACK   = 3'd3,
        RESP  = 3'd4
    } state_t;

endpackage

// File: rtl/sub_arbiter_rr_priority.sv
// Combinational round-robin picker: first set request at or after ptr, searching upward with wrap.
module rr_priority #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = PTR_W'((int'(ptr) + k) % NUM_REQ);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sub_arbiter.sv
// Round-robin arbiter sharing one subtractor between NUM_REQ requesters; sequences
// the start/stb/ack handshake and returns the result with a one-cycle done pulse.
module sub_arbiter
    import kmeans_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b,
    output logic [NUM_REQ-1:0]          done,
    output logic [DATA_W-1:0]           z,
    output logic                        busy,
    output logic [CNT_W-1:0]            op_count,
    output logic                        sub_start,
    output logic [DATA_W-1:0]           sub_a,
    output logic [DATA_W-1:0]           sub_b,
    input  logic                        sub_stb,
    input  logic [DATA_W-1:0]           sub_z,
    output logic                        sub_ack
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state, state_next;
    logic [PTR_W-1:0]   ptr, gidx, pick_idx;
    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [DATA_W-1:0]  pick_a, pick_b, result;
    logic [CNT_W-1:0]   count;

    rr_priority #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr),
        .grant (grant),
        .valid (grant_valid)
    );

    // Convert the one-hot grant into an index and the winner's operand slices.
    always_comb begin
        pick_idx = '0;
        pick_a   = '0;
        pick_b   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                pick_idx = PTR_W'(i);
                pick_a   = req_a[i*DATA_W +: DATA_W];
                pick_b   = req_b[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sub_start  = 1'b0;
        sub_ack    = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (grant_valid) state_next = ISSUE;
            end
            ISSUE: begin
                sub_start  = 1'b1;
                state_next = WAIT;
            end
            WAIT:    if (sub_stb) state_next = ACK;
            ACK: begin
                sub_ack    = 1'b1;
                state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are frozen at grant so requester-side changes cannot disturb the operation in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            gidx   <= '0;
            ptr    <= '0;
            sub_a  <= '0;
            sub_b  <= '0;
            result <= '0;
            z      <= '0;
            done   <= '0;
            count  <= '0;
        end else begin
            done <= '0;
            case (state)
                IDLE: begin
                    if (grant_valid) begin
                        gidx  <= pick_idx;
                        sub_a <= pick_a;
                        sub_b <= pick_b;
                    end
                end
                WAIT:    if (sub_stb) result <= sub_z;
                ACK: begin
                    done[gidx] <= 1'b1;
                    z          <= result;
                end
                RESP: begin
                    count <= count + 1'b1;
                    ptr   <= (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign op_count = count;

endmodule

// File: tb/tb_sub_arbiter.sv
// Scoreboard bench for sub_arbiter with a fixed-latency behavioural subtractor.
module tb_sub_arbiter;

    localparam int N = 4;
    localparam int W = 64;

    typedef struct {
        int          idx;
        logic [W-1:0] z;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic [N*W-1:0] req_a, req_b;
    logic [N-1:0]   done;
    logic [W-1:0]   z;
    logic           busy;
    logic [31:0]    op_count;
    logic           sub_start, sub_ack, sub_stb;
    logic [W-1:0]   sub_a, sub_b, sub_z;

    logic [N-1:0]   keep;
    exp_t           sbq[$];
    int             checks = 0;
    int             fails  = 0;
    int             lat;
    logic           prev_start, prev_ack;

    sub_arbiter #(.NUM_REQ(N), .DATA_W(W)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .req_a     (req_a),
        .req_b     (req_b),
        .done      (done),
        .z         (z),
        .busy      (busy),
        .op_count  (op_count),
        .sub_start (sub_start),
        .sub_a     (sub_a),
        .sub_b     (sub_b),
        .sub_stb   (sub_stb),
        .sub_z     (sub_z),
        .sub_ack   (sub_ack)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Subtractor: stb rises 3 cycles after start, held until ack is sampled.
    always @(posedge clock) begin
        if (reset) begin
            sub_stb <= 1'b0;
            sub_z   <= '0;
            lat     <= 0;
        end else begin
            if (sub_start) begin
                lat   <= 2;
                sub_z <= sub_a - sub_b;
            end else if (lat == 1) begin
                sub_stb <= 1'b1;
                lat     <= 0;
            end else if (lat > 1) begin
                lat <= lat - 1;
            end
            if (sub_stb && sub_ack) sub_stb <= 1'b0;
        end
    end

    // Result monitor: every done pulse must match the head of the scoreboard.
    always @(negedge clock) begin
        if (!reset && (|done)) begin
            if (sbq.size() == 0) begin
                check("unexpected_done", W'(done), '0);
            end else begin
                exp_t e;
                logic [N-1:0] exp_done;
                e = sbq.pop_front();
                exp_done = N'(1) << e.idx;
                check("done_onehot", W'(done), W'(exp_done));
                check("z_value", z, e.z);
            end
        end
    end

    // Handshake phase monitor.
    always @(negedge clock) begin
        if (reset) begin
            prev_start <= 1'b0;
            prev_ack   <= 1'b0;
        end else begin
            if (sub_start) begin
                check("start_single_cycle", W'(prev_start), '0);
                check("start_while_stb", W'(sub_stb), '0);
            end
            if (sub_ack) begin
                check("ack_single_cycle", W'(prev_ack), '0);
                check("ack_without_stb", W'(sub_stb), W'(1'b1));
            end
            prev_start <= sub_start;
            prev_ack   <= sub_ack;
        end
    end

    task automatic tick();
        @(negedge clock);
        if (|done) req = req & ~(done & ~keep);
    endtask

    task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic push(input int i, input logic [W-1:0] v);
        exp_t e;
        e.idx = i;
        e.z   = v;
        sbq.push_back(e);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        keep  = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic wait_start(input int budget);
        int n = 0;
        while (!sub_start && n < budget) begin
            tick();
            n++;
        end
        if (!sub_start) check("start_timeout", W'(sub_start), W'(1'b1));
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((sbq.size() != 0 || busy) && n < budget) begin
            tick();
            n++;
        end
        if (n >= budget) check("drain_timeout", W'(sbq.size()), '0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_done"}, W'(done), '0);
        check({tag, "_z"}, z, '0);
        check({tag, "_busy"}, W'(busy), '0);
        check({tag, "_op_count"}, W'(op_count), '0);
        check({tag, "_sub_start"}, W'(sub_start), '0);
        check({tag, "_sub_ack"}, W'(sub_ack), '0);
        check({tag, "_sub_a"}, sub_a, '0);
        check({tag, "_sub_b"}, sub_b, '0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        req   = '0;
        keep  = '0;
        req_a = '0;
        req_b = '0;
        apply_reset();
        check_reset_state("rst");

        // Single request: 100 - 30
        set_op(0, 64'd100, 64'd30);
        push(0, 64'd70);
        req = 4'b0001;
        tick();
        check("start_latency", W'(sub_start), W'(1'b1));
        wait_drain(50);
        check("single_busy_after_done", W'(busy), '0);
        check("single_op_count", W'(op_count), W'(32'd1));

        // All four together from pointer 0
        apply_reset();
        for (int i = 0; i < N; i++) begin
            set_op(i, W'(10 * i + 50), W'(i));
            push(i, W'(9 * i + 50));
        end
        req = 4'b1111;
        wait_drain(100);
        check("all4_op_count", W'(op_count), W'(32'd4));

        // Fairness: req0 held permanently, req2 joins after the first grant
        apply_reset();
        set_op(0, 64'd20, 64'd5);
        set_op(2, 64'd1000, 64'd1);
        push(0, 64'd15);
        push(2, 64'd999);
        push(0, 64'd15);
        push(2, 64'd999);
        keep = 4'b0001;
        req  = 4'b0001;
        wait_start(10);
        req[2] = 1'b1;
        keep   = 4'b0101;
        begin
            int ndone = 0;
            int n = 0;
            while (ndone < 4 && n < 100) begin
                tick();
                n++;
                if (|done) ndone++;
                if (ndone == 4) begin
                    req  = '0;
                    keep = '0;
                end
            end
            check("fair_done_count", W'(ndone), W'(4));
        end
        wait_drain(50);
        check("fair_op_count", W'(op_count), W'(32'd4));

        // Operand change after grant must not affect the operation
        apply_reset();
        set_op(0, 64'd500, 64'd1);
        push(0, 64'd499);
        req = 4'b0001;
        wait_start(10);
        tick();
        set_op(0, 64'd9, 64'd1);
        tick();
        check("held_sub_a", sub_a, 64'd500);
        wait_drain(50);

        // Reset mid-operation, pointer previously advanced to 1
        apply_reset();
        set_op(0, 64'd3, 64'd1);
        push(0, 64'd2);
        req = 4'b0001;
        wait_drain(50);
        set_op(1, 64'd7, 64'd2);
        req = 4'b0010;
        wait_start(10);
        tick();
        tick();
        check("abort_in_wait_busy", W'(busy), W'(1'b1));
        reset = 1'b1;
        @(negedge clock);
        check_reset_state("abort");
        reset = 1'b0;
        set_op(1, 64'd40, 64'd8);
        push(0, 64'd2);
        push(1, 64'd32);
        req = 4'b0011;
        wait_drain(100);
        check("abort_op_count", W'(op_count), W'(32'd2));

        // op_count wrap, negative difference passes through unmodified
        apply_reset();
        force dut.count = 32'hFFFF_FFFF;
        #1;
        release dut.count;
        check("preload_op_count", W'(op_count), W'(32'hFFFF_FFFF));
        set_op(3, 64'd5, 64'd6);
        push(3, 64'hFFFF_FFFF_FFFF_FFFF);
        req = 4'b1000;
        wait_drain(50);
        check("wrap_op_count", W'(op_count), '0);

        repeat (3) tick();
        check("scoreboard_empty", W'(sbq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
